// File: rtl/multi_frequency_counter.sv
// Multi-channel gated edge counter: counts edges of asynchronous inputs over
// back-to-back gate windows of a programmable length and latches per-channel results.
module multi_frequency_counter #(
    parameter int NUM_CH         = 4,
    parameter int COUNT_W        = 16,
    parameter int PERIOD_W       = 12,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   signal,
    input  logic                mode,
    input  logic                period_load,
    input  logic [PERIOD_W-1:0] period,
    input  logic [2:0]          sel,
    output logic [COUNT_W-1:0]  count_out,
    output logic                ovf_out,
    output logic                valid,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01
    } state_t;

    state_t state, state_next;

    logic [NUM_CH-1:0]   sync1, sync2, hist;
    logic [NUM_CH-1:0]   hit;
    logic [PERIOD_W-1:0] period_reg, gate;
    logic [COUNT_W-1:0]  cnt     [NUM_CH];
    logic [COUNT_W-1:0]  cnt_upd [NUM_CH];
    logic [COUNT_W-1:0]  result  [NUM_CH];
    logic [NUM_CH-1:0]   ovf, ovf_upd, result_ovf;
    logic                load_ok, running, final_cycle, restart;

    // Rising edges only in mode 0; any change of the settled level in mode 1.
    assign hit         = mode ? (sync2 ^ hist) : (sync2 & ~hist);
    assign load_ok     = period_load && (period != '0);
    assign running     = (state == COUNT) && enable;
    assign final_cycle = running && (gate == period_reg - 1'b1);
    assign restart     = running && load_ok && !final_cycle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = COUNT;
            COUNT:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sync1/sync2 absorb metastability; hist is the previous settled level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Saturating increment; overflow records an edge lost at full scale.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_upd[i] = cnt[i];
            ovf_upd[i] = ovf[i];
            if (hit[i]) begin
                if (cnt[i] == '1) ovf_upd[i] = 1'b1;
                else              cnt_upd[i] = cnt[i] + 1'b1;
            end
        end
    end

    // NOTE: result registers are reset as well, so readout is defined before the first window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_reg <= PERIOD_W'(DEFAULT_PERIOD);
            gate       <= '0;
            ovf        <= '0;
            result_ovf <= '0;
            valid      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                result[i] <= '0;
            end
        end else begin
            valid <= final_cycle;
            if (load_ok) period_reg <= period;

            if (!running || restart) begin
                gate <= '0;
                ovf  <= '0;
                for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            end else if (final_cycle) begin
                gate       <= '0;
                ovf        <= '0;
                result_ovf <= ovf_upd;
                for (int i = 0; i < NUM_CH; i++) begin
                    result[i] <= cnt_upd[i];
                    cnt[i]    <= '0;
                end
            end else begin
                gate <= gate + 1'b1;
                ovf  <= ovf_upd;
                for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_upd[i];
            end
        end
    end

    always_comb begin
        count_out = '0;
        ovf_out   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 3'(i)) begin
                count_out = result[i];
                ovf_out   = result_ovf[i];
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_multi_frequency_counter.sv
// Bench for multi_frequency_counter: window-level reference model checked every
// cycle on a 16-bit and an 8-bit instance, plus directed literal expectations.
module tb_multi_frequency_counter;

    localparam int NUM_CH = 4;
    localparam int DEF_P  = 1000;

    logic              clk, reset_n, enable, mode, period_load;
    logic [NUM_CH-1:0] signal;
    logic [11:0]       period;
    logic [2:0]        sel;
    logic [15:0]       count_out;
    logic              ovf_out, valid;
    logic [1:0]        dbg_state;
    logic [7:0]        count_out8;
    logic              ovf_out8, valid8;
    logic [1:0]        dbg_state8;

    multi_frequency_counter dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .signal(signal), .mode(mode),
        .period_load(period_load), .period(period), .sel(sel),
        .count_out(count_out), .ovf_out(ovf_out), .valid(valid), .dbg_state(dbg_state)
    );

    multi_frequency_counter #(.COUNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .signal(signal), .mode(mode),
        .period_load(period_load), .period(period), .sel(sel),
        .count_out(count_out8), .ovf_out(ovf_out8), .valid(valid8), .dbg_state(dbg_state8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wave [NUM_CH];
    int start, prev;

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        n_vec++;
        if (actual !== 32'(expected)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] actual, input int lo, input int hi);
        n_vec++;
        if ($isunknown(actual) || actual < 32'(lo) || actual > 32'(hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
        end
    endtask

    // Reference model: true (unbounded) edge counts per window; saturation is
    // applied only when reading out, per instance width.
    bit                m_run, m_valid, m_load_ok;
    int                m_period, m_elapsed;
    int                m_edges [NUM_CH];
    int                m_res   [NUM_CH];
    logic [NUM_CH-1:0] smp [3];   // settled samples at edges j-3, j-2, j-1
    logic [NUM_CH-1:0] m_qual;

    function automatic int exp_count(input int w, input int idx);
        int max_v;
        max_v = (1 << w) - 1;
        if (idx >= NUM_CH) return 0;
        return (m_res[idx] > max_v) ? max_v : m_res[idx];
    endfunction

    function automatic int exp_ovf(input int w, input int idx);
        if (idx >= NUM_CH) return 0;
        return (m_res[idx] > (1 << w) - 1) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run     = 1'b0;
            m_valid   = 1'b0;
            m_period  = DEF_P;
            m_elapsed = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_edges[ch] = 0;
                m_res[ch]   = 0;
            end
            for (int k = 0; k < 3; k++) smp[k] = '0;
        end else begin
            m_qual    = mode ? (smp[1] ^ smp[0]) : (smp[1] & ~smp[0]);
            m_load_ok = period_load && (period != 0);
            m_valid   = 1'b0;
            if (!m_run) begin
                if (enable) begin
                    m_run     = 1'b1;
                    m_elapsed = 0;
                    for (int ch = 0; ch < NUM_CH; ch++) m_edges[ch] = 0;
                end
            end else if (!enable) begin
                m_run = 1'b0;
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++) if (m_qual[ch]) m_edges[ch]++;
                m_elapsed++;
                if (m_elapsed == m_period) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        m_res[ch]   = m_edges[ch];
                        m_edges[ch] = 0;
                    end
                    m_elapsed = 0;
                    m_valid   = 1'b1;
                end else if (m_load_ok) begin
                    for (int ch = 0; ch < NUM_CH; ch++) m_edges[ch] = 0;
                    m_elapsed = 0;
                end
            end
            if (m_load_ok) m_period = int'(period);
            smp[0] = smp[1];
            smp[1] = smp[2];
            smp[2] = signal;
        end
    end

    always @(negedge clk) begin
        check("valid",      valid,      int'(m_valid));
        check("dbg_state",  dbg_state,  m_run ? 1 : 0);
        check("count_out",  count_out,  exp_count(16, int'(sel)));
        check("ovf_out",    ovf_out,    exp_ovf(16, int'(sel)));
        check("valid8",     valid8,     int'(m_valid));
        check("dbg_state8", dbg_state8, m_run ? 1 : 0);
        check("count_out8", count_out8, exp_count(8, int'(sel)));
        check("ovf_out8",   ovf_out8,   exp_ovf(8, int'(sel)));
    end

    // Advance one cycle; inputs change just after the falling edge.
    // wave: 0 low, 1 square wave of period 10, 2 toggle every cycle, 3 high.
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (wave[ch])
                0:       signal[ch] = 1'b0;
                1:       signal[ch] = ((cyc % 10) < 5);
                2:       signal[ch] = ~signal[ch];
                default: signal[ch] = 1'b1;
            endcase
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (valid !== 1'b1 && n < budget);
        check("valid_timeout", valid, 1);
    endtask

    task automatic pulse_load(input int p);
        period      = 12'(p);
        period_load = 1'b1;
        step();
        period_load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 1'b0; period_load = 1'b0;
        period = '0; sel = '0; signal = '0;
        for (int ch = 0; ch < NUM_CH; ch++) wave[ch] = 0;

        repeat (3) step();
        check("rst_count", count_out, 0);
        check("rst_ovf",   ovf_out,   0);
        check("rst_valid", valid,     0);
        check("rst_state", dbg_state, 0);

        // Default period, rising edges of a period-10 square wave on ch0.
        reset_n = 1'b1; enable = 1'b1; wave[0] = 1;
        start = cyc;
        wait_valid(1100);
        check("first_valid_latency", cyc - start, 1001);
        prev = cyc;
        wait_valid(1100);
        check("valid_spacing", cyc - prev, 1000);
        check_range("mode0_ch0", count_out, 99, 101);

        // Both edges; quiet channel and out-of-range select read zero.
        mode = 1'b1;
        wait_valid(1100);
        wait_valid(1100);
        check_range("mode1_ch0", count_out, 199, 201);
        sel = 3'd1; #1;
        check("mode1_ch1_quiet", count_out, 0);
        sel = 3'd5; #1;
        check("sel_oob_count", count_out, 0);
        check("sel_oob_ovf",   ovf_out,   0);
        sel = 3'd0;

        // Period load mid-window restarts it; zero load ignored; load on the final cycle.
        repeat (300) step();
        start = cyc;
        pulse_load(50);
        wait_valid(100);
        check("load_restart_latency", cyc - start, 51);
        prev = cyc;
        wait_valid(100);
        check("short_window", cyc - prev, 50);
        prev = cyc;
        repeat (10) step();
        pulse_load(0);
        wait_valid(100);
        check("zero_load_ignored", cyc - prev, 50);
        prev = cyc;
        repeat (49) step();
        pulse_load(100);
        check("coincide_valid", valid, 1);
        check("coincide_spacing", cyc - prev, 50);
        prev = cyc;
        wait_valid(200);
        check("coincide_new_period", cyc - prev, 100);

        // Saturation of the 8-bit instance with ch2 toggling every clock.
        wave[2] = 2;
        pulse_load(1000);
        wait_valid(1100);
        sel = 3'd2; #1;
        check("sat8_count", count_out8, 255);
        check("sat8_ovf",   ovf_out8,   1);
        check("sat16_ovf",  ovf_out,    0);
        wave[2] = 0;
        wait_valid(1100);
        wait_valid(1100);
        check("quiet8_count", count_out8, 0);
        check("quiet8_ovf",   ovf_out8,   0);
        sel = 3'd0;

        // Reset in the middle of a window.
        repeat (500) step();
        reset_n = 1'b0; #1;
        check("midrst_count", count_out, 0);
        check("midrst_ovf",   ovf_out,   0);
        check("midrst_valid", valid,     0);
        check("midrst_state", dbg_state, 0);
        repeat (3) step();
        reset_n = 1'b1;
        start = cyc;
        wait_valid(1100);
        check("post_reset_latency", cyc - start, 1001);

        // Enable dropped mid-window: aborted window yields no valid.
        repeat (200) step();
        enable = 1'b0;
        step();
        check("abort_state", dbg_state, 0);
        repeat (5) step();
        enable = 1'b1;
        start = cyc;
        wait_valid(1100);
        check("abort_restart_latency", cyc - start, 1001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
